check_wall: RTL and testbench



---
 rtl/check_wall.sv | 68 ++++++
 tb/tb_check_wall.sv | 136 +++++++++++++
 2 files changed

// File: rtl/check_wall.sv
// check_wall: registered per-pixel wall, dot sprite and game-over row lookup.
// All four outputs come from the same DrawX/DrawY sample, one clock later.
package check_wall_pkg;
  localparam logic [0:29][39:0] MAZE_L1 = {
    40'hFFFFFFFFFF, 40'h8000180001, 40'hBDF99F9FBD, 40'hBDF99F9FBD, 40'h8000000001,
    40'hBD9FFFF9BD, 40'h8180180181, 40'hF9F81F9F9F, 40'h0980001901, 40'hF9BE7DD9FF,
    40'h8000000001, 40'hF9BE7DD9FF, 40'h0980001901, 40'hF9BFFFD9FF, 40'h8000180001,
    40'hBDF99F9FBD, 40'h8C00000031, 40'hEDBFFFDB77, 40'h8180180181, 40'hBFF99F9FFD,
    40'h8000000001, 40'hBDF99F9FBD, 40'h8000000001, 40'hBD9FFFF9BD, 40'h8180180181,
    40'hF9F81F9F9F, 40'h8000000001, 40'hBFFE7FFFFD, 40'h8000000001, 40'hFFFFFFFFFF
  };
  localparam logic [0:29][39:0] GAMEOVER_MAP = {
    40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000,
    40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000,
    40'h03FFFFFFC0, 40'h0200000040, 40'h027A2BEE40, 40'h0242B6A840, 40'h025BAAEC40,
    40'h024A22A840, 40'h027A22EE40, 40'h0200000040, 40'h03FFFFFFC0, 40'h0000000000,
    40'h0074A77400, 40'h0054A64600, 40'h00552C5400, 40'h0074474600, 40'h0000000000,
    40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000
  };
endpackage

module check_wall #(
  parameter logic [0:29][39:0] WALL_MAP = check_wall_pkg::MAZE_L1,
  parameter logic [0:29][39:0] DIED_MAP = check_wall_pkg::GAMEOVER_MAP
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        wall_on,
  output logic [15:0] dot_row,
  output logic        dot_on,
  output logic [39:0] died_row
);
  logic [63:0] wall_rom [64];
  logic [39:0] died_rom [64];
  logic [5:0]  tx, ty;
  logic [3:0]  px, py;
  logic [15:0] dot_next;
  // ROMs padded to the full 6-bit tile range so off-screen tiles read as zero
  for (genvar g = 0; g < 64; g++) begin : g_rom
    if (g < 30) begin : g_map
      assign wall_rom[g] = {24'h0, WALL_MAP[g]};
      assign died_rom[g] = DIED_MAP[g];
    end else begin : g_pad
      assign wall_rom[g] = '0;
      assign died_rom[g] = '0;
    end
  end
  assign tx = DrawX[9:4];
  assign ty = DrawY[9:4];
  assign px = DrawX[3:0];
  assign py = DrawY[3:0];
  assign dot_next = (py >= 4'd6 && py <= 4'd9) ? 16'h03C0 : 16'h0000;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wall_on  <= 1'b0;
      dot_row  <= '0;
      dot_on   <= 1'b0;
      died_row <= '0;
    end else begin
      wall_on  <= wall_rom[ty][tx];
      dot_row  <= dot_next;
      dot_on   <= dot_next[px];
      died_row <= died_rom[ty];
    end
  end
endmodule

// File: tb/tb_check_wall.sv
// tb_check_wall: table vectors, random pixels and sweeps against a tile-arithmetic model.
module tb_check_wall;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic wall_on, dot_on;
  logic [15:0] dot_row;
  logic [39:0] died_row;
  int total = 0, bad = 0;

  localparam logic [39:0] MAZE [30] = '{
    40'hFFFFFFFFFF, 40'h8000180001, 40'hBDF99F9FBD, 40'hBDF99F9FBD, 40'h8000000001,
    40'hBD9FFFF9BD, 40'h8180180181, 40'hF9F81F9F9F, 40'h0980001901, 40'hF9BE7DD9FF,
    40'h8000000001, 40'hF9BE7DD9FF, 40'h0980001901, 40'hF9BFFFD9FF, 40'h8000180001,
    40'hBDF99F9FBD, 40'h8C00000031, 40'hEDBFFFDB77, 40'h8180180181, 40'hBFF99F9FFD,
    40'h8000000001, 40'hBDF99F9FBD, 40'h8000000001, 40'hBD9FFFF9BD, 40'h8180180181,
    40'hF9F81F9F9F, 40'h8000000001, 40'hBFFE7FFFFD, 40'h8000000001, 40'hFFFFFFFFFF
  };
  localparam logic [39:0] GO [30] = '{
    40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000,
    40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000,
    40'h03FFFFFFC0, 40'h0200000040, 40'h027A2BEE40, 40'h0242B6A840, 40'h025BAAEC40,
    40'h024A22A840, 40'h027A22EE40, 40'h0200000040, 40'h03FFFFFFC0, 40'h0000000000,
    40'h0074A77400, 40'h0054A64600, 40'h00552C5400, 40'h0074474600, 40'h0000000000,
    40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000, 40'h0000000000
  };

  typedef struct packed {
    logic        wall;
    logic [15:0] dr;
    logic        don;
    logic [39:0] died;
  } exp_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    exp_t       e;
  } vec_t;

  exp_t prev;
  exp_t zero;
  vec_t tbl [12];

  always #5 clk = ~clk;

  check_wall dut (
    .Clk(clk), .Reset_n(rst_n), .DrawX(x), .DrawY(y),
    .wall_on(wall_on), .dot_row(dot_row), .dot_on(dot_on), .died_row(died_row)
  );

  function automatic exp_t model(int px, int py);
    exp_t e;
    int tx = px / 16;
    int ty = py / 16;
    int sy = py % 16;
    e.wall = (tx < 40 && ty < 30) ? MAZE[ty][tx] : 1'b0;
    e.dr   = (sy >= 6 && sy <= 9) ? 16'h03C0 : 16'h0000;
    e.don  = e.dr[px % 16];
    e.died = (ty < 30) ? GO[ty] : 40'h0;
    return e;
  endfunction

  task automatic chk(string n, logic [39:0] act, logic [39:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask

  task automatic chk_all(string n, exp_t e);
    chk({n, " wall_on"}, 40'(wall_on), 40'(e.wall));
    chk({n, " dot_row"}, 40'(dot_row), 40'(e.dr));
    chk({n, " dot_on"}, 40'(dot_on), 40'(e.don));
    chk({n, " died_row"}, died_row, e.died);
  endtask

  // Drive between edges; outputs must hold the previous sample until the edge.
  task automatic apply(string n, int px, int py, exp_t e);
    @(negedge clk);
    x = px[9:0];
    y = py[9:0];
    #1 chk_all({n, " hold"}, prev);
    @(posedge clk);
    #1 chk_all(n, e);
    prev = e;
  endtask

  initial begin
    zero = '0;
    tbl = '{
      '{10'd0,   10'd16,   '{1'b1, 16'h0000, 1'b0, 40'h0}},
      '{10'd16,  10'd16,   '{1'b0, 16'h0000, 1'b0, 40'h0}},
      '{10'd304, 10'd16,   '{1'b1, 16'h0000, 1'b0, 40'h0}},
      '{10'd320, 10'd16,   '{1'b1, 16'h0000, 1'b0, 40'h0}},
      '{10'd624, 10'd16,   '{1'b1, 16'h0000, 1'b0, 40'h0}},
      '{10'd32,  10'd16,   '{1'b0, 16'h0000, 1'b0, 40'h0}},
      '{10'd7,   10'd23,   '{1'b1, 16'h03C0, 1'b1, 40'h0}},
      '{10'd5,   10'd23,   '{1'b1, 16'h03C0, 1'b0, 40'h0}},
      '{10'd640, 10'd0,    '{1'b0, 16'h0000, 1'b0, 40'h0}},
      '{10'd5,   10'd480,  '{1'b0, 16'h0000, 1'b0, 40'h0}},
      '{10'd5,   10'd1008, '{1'b0, 16'h0000, 1'b0, 40'h0}},
      '{10'd200, 10'd198,  '{1'b1, 16'h03C0, 1'b1, 40'h027A2BEE40}}
    };
    x = 10'd5;
    y = 10'd5;
    repeat (3) @(posedge clk);
    #1 chk_all("reset held", zero);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("reset release", model(5, 5));
    chk("release wall_on", 40'(wall_on), 40'h1);
    prev = model(5, 5);
    for (int i = 0; i < 12; i++)
      apply($sformatf("vec%0d", i), int'(tbl[i].x), int'(tbl[i].y), tbl[i].e);
    for (int t = 0; t < 30; t++)
      apply($sformatf("died ty%0d", t), 3, t * 16, model(3, t * 16));
    for (int i = 0; i < 300; i++) begin
      int rx = int'($urandom_range(0, 1023));
      int ry = int'($urandom_range(0, 1023));
      apply($sformatf("rand x%0d y%0d", rx, ry), rx, ry, model(rx, ry));
    end
    for (int sx = 0; sx < 640; sx++)
      apply($sformatf("sweep x%0d", sx), sx, 80, model(sx, 80));
    @(negedge clk);
    x = 10'd100;
    y = 10'd80;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async reset", zero);
    @(posedge clk);
    #1 chk_all("reset across edge", zero);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
